// File: rtl/lsp_mem_pkg.sv
// Shared definitions for the load-store memory stage: access width codes,
// FSM state encoding and the byte-enable pattern for each width.
package lsp_mem_pkg;

   localparam logic [1:0] MW_B = 2'b00;
   localparam logic [1:0] MW_H = 2'b01;
   localparam logic [1:0] MW_W = 2'b10;
   localparam logic [1:0] MW_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10,
      ST_WB   = 2'b11
   } lsp_state_e;

   function automatic logic [7:0] width_mask(input logic [1:0] width);
      case (width)
         MW_B:    return 8'h01;
         MW_H:    return 8'h03;
         MW_W:    return 8'h0F;
         MW_D:    return 8'hFF;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsp_mem_if.sv
// Issue, data-memory and writeback signals of the memory stage. The master
// modport is the stage itself; slave is its environment.
interface lsp_mem_if;

   logic [63:0] ix_lsp_pc;
   logic [4:0]  ix_lsp_dst;
   logic        ix_lsp_wb_en;
   logic [63:0] ix_lsp_base;
   logic [11:0] ix_lsp_offset;
   logic [63:0] ix_lsp_store_data;
   logic        ix_lsp_mem_wen;
   logic [1:0]  ix_lsp_mem_width;
   logic        ix_lsp_mem_sign;
   logic        ix_lsp_valid;
   logic        ix_lsp_ready;

   logic [63:0] dm_req_addr;
   logic        dm_req_wen;
   logic [63:0] dm_req_wdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic [63:0] dm_resp_rdata;
   logic        dm_resp_valid;

   logic [4:0]  lsp_wb_dst;
   logic [63:0] lsp_wb_result;
   logic [63:0] lsp_wb_pc;
   logic        lsp_wb_wb_en;
   logic        lsp_wb_misalign;
   logic        lsp_wb_valid;
   logic        lsp_wb_ready;

   modport master (
      input  ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset,
             ix_lsp_store_data, ix_lsp_mem_wen, ix_lsp_mem_width, ix_lsp_mem_sign,
             ix_lsp_valid,
      output ix_lsp_ready,
      output dm_req_addr, dm_req_wen, dm_req_wdata, dm_req_wmask, dm_req_valid,
      input  dm_req_ready, dm_resp_rdata, dm_resp_valid,
      output lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en, lsp_wb_misalign,
             lsp_wb_valid,
      input  lsp_wb_ready
   );

   modport slave (
      output ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset,
             ix_lsp_store_data, ix_lsp_mem_wen, ix_lsp_mem_width, ix_lsp_mem_sign,
             ix_lsp_valid,
      input  ix_lsp_ready,
      input  dm_req_addr, dm_req_wen, dm_req_wdata, dm_req_wmask, dm_req_valid,
      output dm_req_ready, dm_resp_rdata, dm_resp_valid,
      input  lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en, lsp_wb_misalign,
             lsp_wb_valid,
      output lsp_wb_ready
   );

endinterface

// File: rtl/lsp_mem_align.sv
// Combinational lane logic: effective address, misalign detection, store
// lane shift/mask, and load shift with sign/zero extension.
module lsp_mem_align
   import lsp_mem_pkg::*;
(
   input  logic [63:0] base_i,
   input  logic [11:0] offset_i,
   input  logic [1:0]  width_i,
   input  logic [63:0] store_data_i,
   output logic [63:0] ea_o,
   output logic        misalign_o,
   output logic [63:0] wdata_o,
   output logic [7:0]  wmask_o,
   input  logic [2:0]  ld_lane_i,
   input  logic [1:0]  ld_width_i,
   input  logic        ld_sign_i,
   input  logic [63:0] rdata_i,
   output logic [63:0] ld_data_o
);

   logic [63:0] shifted_s;

   // Issue-side address, alignment and store lane placement.
   always_comb begin
      ea_o = base_i + {{52{offset_i[11]}}, offset_i};
      case (width_i)
         MW_B:    misalign_o = 1'b0;
         MW_H:    misalign_o = ea_o[0];
         MW_W:    misalign_o = |ea_o[1:0];
         MW_D:    misalign_o = |ea_o[2:0];
         default: misalign_o = 1'b0;
      endcase
      wdata_o = store_data_i << {ea_o[2:0], 3'b000};
      wmask_o = width_mask(width_i) << ea_o[2:0];
   end

   // Response-side lane extraction and extension.
   always_comb begin
      shifted_s = rdata_i >> {ld_lane_i, 3'b000};
      case (ld_width_i)
         MW_B:    ld_data_o = {{56{ld_sign_i & shifted_s[7]}},  shifted_s[7:0]};
         MW_H:    ld_data_o = {{48{ld_sign_i & shifted_s[15]}}, shifted_s[15:0]};
         MW_W:    ld_data_o = {{32{ld_sign_i & shifted_s[31]}}, shifted_s[31:0]};
         MW_D:    ld_data_o = shifted_s;
         default: ld_data_o = shifted_s;
      endcase
   end

endmodule

// File: rtl/lsp_mem.sv
// Memory stage of the load-store pipe: one blocking load/store in flight,
// single-outstanding data-memory port, registered writeback presentation.
module lsp_mem
   import lsp_mem_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   lsp_mem_if.master io
);

   lsp_state_e  state_q, state_d;
   logic [63:0] pc_q;
   logic [4:0]  dst_q;
   logic        wb_en_q;
   logic        mis_q;
   logic [63:0] result_q;
   logic [63:0] req_addr_q;
   logic [63:0] req_wdata_q;
   logic [7:0]  req_wmask_q;
   logic        req_wen_q;
   logic [2:0]  lane_q;
   logic [1:0]  width_q;
   logic        sign_q;

   logic [63:0] ea_s;
   logic        mis_s;
   logic [63:0] wdata_s;
   logic [7:0]  wmask_s;
   logic [63:0] ld_data_s;
   logic        issue_s;
   logic        resp_s;

   assign issue_s = (state_q == ST_IDLE) && io.ix_lsp_valid;
   assign resp_s  = (state_q == ST_RESP) && io.dm_resp_valid;

   lsp_mem_align u_align (
      .base_i       (io.ix_lsp_base),
      .offset_i     (io.ix_lsp_offset),
      .width_i      (io.ix_lsp_mem_width),
      .store_data_i (io.ix_lsp_store_data),
      .ea_o         (ea_s),
      .misalign_o   (mis_s),
      .wdata_o      (wdata_s),
      .wmask_o      (wmask_s),
      .ld_lane_i    (lane_q),
      .ld_width_i   (width_q),
      .ld_sign_i    (sign_q),
      .rdata_i      (io.dm_resp_rdata),
      .ld_data_o    (ld_data_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (io.ix_lsp_valid) begin
               state_d = mis_s ? ST_WB : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (io.dm_req_ready) begin
               state_d = req_wen_q ? ST_WB : ST_RESP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: begin
            if (io.dm_resp_valid) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_WB: begin
            if (io.lsp_wb_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WB;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request fields are captured at issue so they hold still until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= 64'd0;
         dst_q       <= 5'd0;
         wb_en_q     <= 1'b0;
         mis_q       <= 1'b0;
         result_q    <= 64'd0;
         req_addr_q  <= 64'd0;
         req_wdata_q <= 64'd0;
         req_wmask_q <= 8'd0;
         req_wen_q   <= 1'b0;
         lane_q      <= 3'd0;
         width_q     <= 2'd0;
         sign_q      <= 1'b0;
      end else if (issue_s) begin
         pc_q        <= io.ix_lsp_pc;
         dst_q       <= io.ix_lsp_dst;
         wb_en_q     <= io.ix_lsp_wb_en & ~io.ix_lsp_mem_wen & ~mis_s;
         mis_q       <= mis_s;
         result_q    <= 64'd0;
         req_addr_q  <= {ea_s[63:3], 3'b000};
         req_wdata_q <= wdata_s;
         req_wmask_q <= wmask_s;
         req_wen_q   <= io.ix_lsp_mem_wen & ~mis_s;
         lane_q      <= ea_s[2:0];
         width_q     <= io.ix_lsp_mem_width;
         sign_q      <= io.ix_lsp_mem_sign;
      end else if (resp_s) begin
         result_q    <= ld_data_s;
      end
   end

   // Output decode; depends only on registered state, never on inputs.
   always_comb begin
      io.ix_lsp_ready    = (state_q == ST_IDLE);
      io.dm_req_valid    = (state_q == ST_REQ);
      io.lsp_wb_valid    = (state_q == ST_WB);
      io.dm_req_addr     = req_addr_q;
      io.dm_req_wen      = req_wen_q;
      io.dm_req_wdata    = req_wdata_q;
      io.dm_req_wmask    = req_wmask_q;
      io.lsp_wb_dst      = dst_q;
      io.lsp_wb_result   = result_q;
      io.lsp_wb_pc       = pc_q;
      io.lsp_wb_wb_en    = wb_en_q;
      io.lsp_wb_misalign = mis_q;
   end

endmodule

// File: tb/tb_lsp_mem.sv
// Bench for lsp_mem: byte-addressed memory model, directed and randomized
// loads/stores with memory and writeback back-pressure, and mid-flight reset.
module tb_lsp_mem;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [7:0] mem [logic [63:0]];

   always #5 clk = ~clk;

   lsp_mem_if io ();

   lsp_mem dut (
      .clk (clk),
      .rst (rst),
      .io  (io.master)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mem_rd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic mem_wr_dw(input logic [63:0] a, input logic [63:0] v);
      for (int i = 0; i < 8; i++) mem[a + 64'(i)] = v[8*i +: 8];
   endtask

   task automatic run_op(input logic [63:0] pc, input logic [63:0] base, input logic [11:0] off,
                         input logic [63:0] sd, input logic wen, input logic [1:0] w,
                         input logic sgn, input logic [4:0] dst, input logic wbe,
                         input int rq_d, input int rs_d, input int wb_d);
      logic [63:0] ea, dw, exp_res, obs, exp_sd, rd;
      logic [7:0]  exp_mask;
      int          nb, lane;
      bit          mis;
      logic        exp_wben;
      ea       = base + {{52{off[11]}}, off};
      nb       = 1 << w;
      mis      = (ea % 64'(nb)) != 64'd0;
      lane     = int'(ea % 64'd8);
      dw       = ea - (ea % 64'd8);
      exp_mask = 8'(((1 << nb) - 1) << lane);
      exp_sd   = (nb == 8) ? sd : (sd & ((64'd1 << (8 * nb)) - 64'd1));
      exp_res  = 64'd0;
      for (int i = 0; i < nb; i++) exp_res |= 64'(mem_rd(ea + 64'(i))) << (8 * i);
      if (sgn && nb < 8 && exp_res[8*nb-1]) exp_res |= ~((64'd1 << (8 * nb)) - 64'd1);
      if (wen) exp_res = 64'd0;
      exp_wben = wbe && !wen && !mis;

      io.ix_lsp_pc = pc; io.ix_lsp_dst = dst; io.ix_lsp_wb_en = wbe;
      io.ix_lsp_base = base; io.ix_lsp_offset = off; io.ix_lsp_store_data = sd;
      io.ix_lsp_mem_wen = wen; io.ix_lsp_mem_width = w; io.ix_lsp_mem_sign = sgn;
      io.ix_lsp_valid = 1'b1;
      check_val("issue_ready", io.ix_lsp_ready, 1'b1);
      tick();
      io.ix_lsp_valid = 1'b0;
      io.ix_lsp_base = {$urandom, $urandom}; io.ix_lsp_store_data = {$urandom, $urandom};
      io.ix_lsp_pc = {$urandom, $urandom}; io.ix_lsp_offset = 12'($urandom);

      if (mis) begin
         check_val("mis_wb_at_t1", io.lsp_wb_valid, 1'b1);
         check_val("mis_no_req", io.dm_req_valid, 1'b0);
      end else begin
         check_val("wb_not_early", io.lsp_wb_valid, 1'b0);
         for (int c = 0; c <= rq_d; c++) begin
            check_val("req_valid", io.dm_req_valid, 1'b1);
            check_val("req_addr", io.dm_req_addr, dw);
            check_val("req_wen", io.dm_req_wen, wen);
            check_val("req_busy", io.ix_lsp_ready, 1'b0);
            if (wen) begin
               check_val("req_wmask", io.dm_req_wmask, exp_mask);
               obs = 64'd0;
               for (int i = 0; i < nb; i++) obs |= 64'(io.dm_req_wdata[8*(lane+i) +: 8]) << (8 * i);
               check_val("req_wdata", obs, exp_sd);
            end
            if (c == rq_d) begin
               io.dm_req_ready = 1'b1;
            end else begin
               io.dm_resp_valid = 1'($urandom);
               io.dm_resp_rdata = {$urandom, $urandom};
            end
            tick();
            io.dm_req_ready = 1'b0;
            io.dm_resp_valid = 1'b0;
         end
         if (!wen) begin
            for (int c = 0; c <= rs_d; c++) begin
               check_val("resp_wait", {io.lsp_wb_valid, io.dm_req_valid}, 2'b00);
               if (c == rs_d) begin
                  for (int i = 0; i < 8; i++) rd[8*i +: 8] = mem_rd(dw + 64'(i));
                  io.dm_resp_rdata = rd;
                  io.dm_resp_valid = 1'b1;
               end else begin
                  io.dm_resp_rdata = {$urandom, $urandom};
               end
               tick();
               io.dm_resp_valid = 1'b0;
               io.dm_resp_rdata = {$urandom, $urandom};
            end
         end
      end

      for (int c = 0; c <= wb_d; c++) begin
         check_val("wb_valid", io.lsp_wb_valid, 1'b1);
         check_val("wb_pc", io.lsp_wb_pc, pc);
         check_val("wb_dst", io.lsp_wb_dst, dst);
         check_val("wb_en", io.lsp_wb_wb_en, exp_wben);
         check_val("wb_misalign", io.lsp_wb_misalign, mis);
         check_val("wb_busy", {io.ix_lsp_ready, io.dm_req_valid}, 2'b00);
         if (!mis) check_val("wb_result", io.lsp_wb_result, exp_res);
         if (c == wb_d) io.lsp_wb_ready = 1'b1;
         tick();
         io.lsp_wb_ready = 1'b0;
      end
      check_val("back_to_idle", {io.lsp_wb_valid, io.ix_lsp_ready}, 2'b01);

      if (wen && !mis) begin
         for (int i = 0; i < nb; i++) mem[ea + 64'(i)] = sd[8*i +: 8];
      end
   endtask

   initial begin
      logic [63:0] base;
      logic [11:0] off;
      rst = 1'b1;
      io.ix_lsp_pc = 64'd0; io.ix_lsp_dst = 5'd0; io.ix_lsp_wb_en = 1'b0;
      io.ix_lsp_base = 64'd0; io.ix_lsp_offset = 12'd0; io.ix_lsp_store_data = 64'd0;
      io.ix_lsp_mem_wen = 1'b0; io.ix_lsp_mem_width = 2'd0; io.ix_lsp_mem_sign = 1'b0;
      io.ix_lsp_valid = 1'b0; io.dm_req_ready = 1'b0; io.dm_resp_rdata = 64'd0;
      io.dm_resp_valid = 1'b0; io.lsp_wb_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check_val("rst_ready", io.ix_lsp_ready, 1'b1);
      check_val("rst_valids", {io.dm_req_valid, io.lsp_wb_valid}, 2'b00);
      check_val("rst_flags", {io.dm_req_wen, io.lsp_wb_wb_en, io.lsp_wb_misalign}, 3'b000);
      check_val("rst_addr", io.dm_req_addr, 64'd0);
      check_val("rst_result", io.lsp_wb_result, 64'd0);

      mem_wr_dw(64'h1008, 64'h1122334455667788);
      mem_wr_dw(64'h1000, 64'h0000000080000000);
      run_op(64'h400, 64'h1000, 12'd8, 64'd0, 1'b0, 2'b11, 1'b0, 5'd5, 1'b1, 0, 0, 0);
      run_op(64'h404, 64'h1000, 12'd3, 64'd0, 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 0, 0, 0);
      run_op(64'h408, 64'h1000, 12'd3, 64'd0, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1, 0, 0, 0);
      run_op(64'h40C, 64'h1000, 12'd6, 64'hBEEF, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 0, 0, 0);
      run_op(64'h410, 64'h1000, 12'd2, 64'd0, 1'b0, 2'b10, 1'b0, 5'd8, 1'b1, 0, 0, 0);
      run_op(64'h414, 64'h1000, 12'd6, 64'd0, 1'b0, 2'b01, 1'b1, 5'd9, 1'b1, 0, 0, 0);
      run_op(64'h418, 64'h1010, 12'hFF8, 64'd0, 1'b0, 2'b11, 1'b0, 5'd10, 1'b1, 3, 4, 2);
      run_op(64'h41C, 64'h1000, 12'd4, 64'hCAFEF00D, 1'b1, 2'b10, 1'b0, 5'd0, 1'b0, 3, 0, 2);
      run_op(64'h420, 64'hFFFF_FFFF_FFFF_FFF8, 12'h010, 64'd0, 1'b0, 2'b10, 1'b1, 5'd11, 1'b0, 0, 1, 0);

      for (int k = 0; k < 200; k++) begin
         base = 64'h2000 + 64'($urandom_range(0, 63) * 8) +
                (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : 64'd0);
         off  = 12'($urandom_range(0, 31) * 8) - 12'd128;
         run_op({$urandom, $urandom}, base, off, {$urandom, $urandom}, 1'($urandom),
                2'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      io.ix_lsp_base = 64'h1000; io.ix_lsp_offset = 12'd0; io.ix_lsp_mem_wen = 1'b0;
      io.ix_lsp_mem_width = 2'b11; io.ix_lsp_wb_en = 1'b1; io.ix_lsp_valid = 1'b1;
      tick();
      io.ix_lsp_valid = 1'b0;
      io.dm_req_ready = 1'b1;
      tick();
      io.dm_req_ready = 1'b0;
      rst = 1'b1;
      #2;
      check_val("rst_async_idle", {io.ix_lsp_ready, io.dm_req_valid, io.lsp_wb_valid}, 3'b100);
      tick();
      rst = 1'b0;
      io.dm_resp_rdata = 64'hDEAD_BEEF_0000_0001;
      io.dm_resp_valid = 1'b1;
      tick();
      io.dm_resp_valid = 1'b0;
      check_val("late_resp_ignored", {io.ix_lsp_ready, io.lsp_wb_valid}, 2'b10);
      tick();
      check_val("late_resp_idle", {io.ix_lsp_ready, io.lsp_wb_valid, io.dm_req_valid}, 3'b100);
      check_val("late_resp_result", io.lsp_wb_result, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
